// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//
// Bank of N_CH independent button/switch debouncers. Each raw input goes
// through a two-flop synchronizer. A per-channel counter then measures how
// long the synchronized value has differed from the current debounced level.
// The new level is accepted only after STABLE_CNT consecutive differing
// cycles. Any bounce back to the current level restarts the count from zero.
//
// Optional feature (compile-time macro DEBOUNCE_AUTOREPEAT_EN):
//   While a channel's debounced level stays high, rise_pulse re-fires once
//   REPEAT_DLY cycles after the accepted rise, and then every REPEAT_PER
//   cycles. A falling acceptance stops the repeats and clears the timer.
//   Without the macro, no repeat timers are built.
//
// Parameters:
//   N_CH        number of channels (1..32)
//   STABLE_CNT  stable cycles needed to accept a new level (>= 2)
//   CNT_W       counter width, 2**CNT_W > STABLE_CNT
//   REPEAT_DLY  auto-repeat initial delay (auto-repeat build only)
//   REPEAT_PER  auto-repeat period       (auto-repeat build only)
//
// Ports:
//   clk         system clock, rising edge
//   btn_reset   asynchronous, active-high reset
//   raw_in      raw asynchronous levels, one bit per channel
//   level_out   debounced level per channel (registered)
//   rise_pulse  one-cycle pulse per accepted 0->1 (plus repeats) (registered)
//   fall_pulse  one-cycle pulse per accepted 1->0 (registered)
// -----------------------------------------------------------------------------
module debounce_bank #(
    parameter int N_CH       = 8,
    parameter int STABLE_CNT = 3000000,
    parameter int CNT_W      = 22,
    parameter int REPEAT_DLY = 50000000,
    parameter int REPEAT_PER = 20000000
) (
    input  logic            clk,
    input  logic            btn_reset,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse
);

    // Reject illegal configurations at elaboration time.
    if ((N_CH < 1) || (N_CH > 32) || (STABLE_CNT < 2) ||
        ((64'd1 << CNT_W) <= 64'(STABLE_CNT)) ||
        (REPEAT_DLY < 1) || (REPEAT_PER < 1)) begin : g_bad_cfg
        $error("debounce_bank: illegal parameter combination");
    end

    logic [N_CH-1:0]            sync1_r;
    logic [N_CH-1:0]            sync2_r;
    logic [N_CH-1:0][CNT_W-1:0] cnt_r;
    logic [N_CH-1:0][CNT_W-1:0] cnt_nxt_s;
    logic [N_CH-1:0]            sync_diff_s;
    logic [N_CH-1:0]            accept_s;
    logic [N_CH-1:0]            rep_fire_s;

    // Per-channel stability counter: clears whenever the synchronized value
    // matches the level, accepts and clears on reaching STABLE_CNT-1, and
    // never goes beyond STABLE_CNT-1.
    always_comb begin
        sync_diff_s = sync2_r ^ level_out;
        accept_s    = {N_CH{1'b0}};
        cnt_nxt_s   = cnt_r;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (!sync_diff_s[ch]) begin
                cnt_nxt_s[ch] = {CNT_W{1'b0}};
            end else if (cnt_r[ch] == CNT_W'(STABLE_CNT - 1)) begin
                accept_s[ch]  = 1'b1;
                cnt_nxt_s[ch] = {CNT_W{1'b0}};
            end else begin
                cnt_nxt_s[ch] = cnt_r[ch] + CNT_W'(1);
            end
        end
    end

    // Synchronizers, counters, debounced level and edge pulses.
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            sync1_r    <= {N_CH{1'b0}};
            sync2_r    <= {N_CH{1'b0}};
            cnt_r      <= {(N_CH*CNT_W){1'b0}};
            level_out  <= {N_CH{1'b0}};
            rise_pulse <= {N_CH{1'b0}};
            fall_pulse <= {N_CH{1'b0}};
        end else begin
            sync1_r    <= raw_in;
            sync2_r    <= sync1_r;
            cnt_r      <= cnt_nxt_s;
            // An accepted channel always flips, so the new level is sync2_r.
            level_out  <= level_out ^ accept_s;
            rise_pulse <= (accept_s & sync2_r) | rep_fire_s;
            fall_pulse <= accept_s & ~sync2_r;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [N_CH-1:0][REP_W-1:0] rep_cnt_r;
    logic [N_CH-1:0][REP_W-1:0] rep_cnt_nxt_s;
    logic [N_CH-1:0]            rep_first_r;
    logic [N_CH-1:0]            rep_first_nxt_s;

    // Repeat timer: counts cycles since the last rise pulse while the level
    // is high. rep_first_r selects the initial delay over the period. An
    // acceptance in either direction restarts the timer. A channel that is
    // accepting a fall never repeats in that cycle, so rise and fall stay
    // exclusive.
    always_comb begin
        rep_fire_s      = {N_CH{1'b0}};
        rep_cnt_nxt_s   = rep_cnt_r;
        rep_first_nxt_s = rep_first_r;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (accept_s[ch]) begin
                rep_cnt_nxt_s[ch]   = {REP_W{1'b0}};
                rep_first_nxt_s[ch] = 1'b1;
            end else if (level_out[ch]) begin
                if (rep_cnt_r[ch] == (rep_first_r[ch] ? REP_W'(REPEAT_DLY - 1)
                                                      : REP_W'(REPEAT_PER - 1))) begin
                    rep_fire_s[ch]      = 1'b1;
                    rep_cnt_nxt_s[ch]   = {REP_W{1'b0}};
                    rep_first_nxt_s[ch] = 1'b0;
                end else begin
                    rep_cnt_nxt_s[ch] = rep_cnt_r[ch] + REP_W'(1);
                end
            end else begin
                rep_cnt_nxt_s[ch]   = {REP_W{1'b0}};
                rep_first_nxt_s[ch] = 1'b1;
            end
        end
    end

    // Repeat timer state.
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            rep_cnt_r   <= {(N_CH*REP_W){1'b0}};
            rep_first_r <= {N_CH{1'b0}};
        end else begin
            rep_cnt_r   <= rep_cnt_nxt_s;
            rep_first_r <= rep_first_nxt_s;
        end
    end
`else
    assign rep_fire_s = {N_CH{1'b0}};
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_debounce_bank
//
// Self-checking bench for debounce_bank (N_CH=4, STABLE_CNT=4, REPEAT_DLY=10,
// REPEAT_PER=5). The reference model keeps a sliding window of raw samples.
// A channel flips when the last STABLE_CNT synchronized samples all differ
// from its current level. Repeats are derived from the age since the
// accepted rise.
// -----------------------------------------------------------------------------
module tb_debounce_bank;

    localparam int N_CH = 4;
    localparam int S    = 4;
    localparam int DLY  = 10;
    localparam int PER  = 5;

    logic            clk = 1'b0;
    logic            btn_reset = 1'b0;
    logic [N_CH-1:0] raw_in = 4'b0000;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;

    int checks = 0;
    int errors = 0;

    debounce_bank #(
        .N_CH      (N_CH),
        .STABLE_CNT(S),
        .CNT_W     (3),
        .REPEAT_DLY(DLY),
        .REPEAT_PER(PER)
    ) dut (
        .clk       (clk),
        .btn_reset (btn_reset),
        .raw_in    (raw_in),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // hist[0] is the raw value sampled at the previous edge. The synchronizer
    // makes hist[1..S] the synchronized values seen at the last S edges.
    logic [N_CH-1:0] hist [0:S];
    logic [N_CH-1:0] m_level;
    logic [N_CH-1:0] m_rise;
    logic [N_CH-1:0] m_fall;
    int              m_age [N_CH];

    function automatic logic window_differs(int ch);
        for (int k = 1; k <= S; k++) begin
            if (hist[k][ch] == m_level[ch]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic is_repeat(int age);
        return (age == DLY) || ((age > DLY) && (((age - DLY) % PER) == 0));
    endfunction

    always @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            for (int k = 0; k <= S; k++) hist[k] <= '0;
            m_level <= '0;
            m_rise  <= '0;
            m_fall  <= '0;
            for (int ch = 0; ch < N_CH; ch++) m_age[ch] <= 0;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (window_differs(ch)) begin
                    m_level[ch] <= ~m_level[ch];
                    m_rise[ch]  <= ~m_level[ch];
                    m_fall[ch]  <= m_level[ch];
                    m_age[ch]   <= 0;
                end else begin
                    m_fall[ch] <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                    if (m_level[ch]) begin
                        m_age[ch]  <= m_age[ch] + 1;
                        m_rise[ch] <= is_repeat(m_age[ch] + 1);
                    end else begin
                        m_age[ch]  <= 0;
                        m_rise[ch] <= 1'b0;
                    end
`else
                    m_rise[ch] <= 1'b0;
`endif
                end
            end
            hist[0] <= raw_in;
            for (int k = 1; k <= S; k++) hist[k] <= hist[k-1];
        end
    end

    // ---------------- stimulus helper ----------------
    task automatic do_reset();
        @(negedge clk);
        btn_reset = 1'b1;
        raw_in    = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        btn_reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        btn_reset = 1'b0;
        #2;
        btn_reset = 1'b1;
        #1;
        checks++;
        if ({level_out, rise_pulse, fall_pulse} !== 12'h000) begin
            errors++;
            $display("FAIL reset_async: got %h expected 000", {level_out, rise_pulse, fall_pulse});
        end
        @(negedge clk);
        @(negedge clk);
        btn_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({level_out, rise_pulse, fall_pulse} !== 12'h000) begin
                errors++;
                $display("FAIL reset_idle: got %h expected 000", {level_out, rise_pulse, fall_pulse});
            end
        end
    endtask

    task automatic test_latency();
        int first = 0;
        int n_rise = 0;
        int rise_at = 0;
        do_reset();
        raw_in = 4'b0001;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (level_out[0] && (first == 0)) first = i;
            if (rise_pulse[0]) begin
                n_rise++;
                rise_at = i;
            end
            checks++;
            if ({level_out[3:1], rise_pulse[3:1], fall_pulse} !== 10'd0) begin
                errors++;
                $display("FAIL latency_others: cycle %0d got %b expected 0", i,
                         {level_out[3:1], rise_pulse[3:1], fall_pulse});
            end
        end
        checks++;
        if (first !== 6) begin
            errors++;
            $display("FAIL latency_level: got %0d expected 6", first);
        end
        checks++;
        if ((n_rise !== 1) || (rise_at !== 6)) begin
            errors++;
            $display("FAIL latency_pulse: got count %0d at %0d expected 1 at 6", n_rise, rise_at);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 6; i++) begin
                raw_in = (i < 3) ? 4'b0010 : 4'b0000;
                @(negedge clk);
                checks++;
                if ({level_out, rise_pulse, fall_pulse} !== 12'h000) begin
                    errors++;
                    $display("FAIL glitch: burst %0d cycle %0d got %h expected 000", r, i,
                             {level_out, rise_pulse, fall_pulse});
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int lvl_at = 0;
        int n_full = 0;
        int n_part = 0;
        do_reset();
        raw_in = 4'b1111;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if ((level_out == 4'b1111) && (lvl_at == 0)) lvl_at = i;
            if (level_out != 4'b0000 && level_out != 4'b1111) n_part++;
            if (rise_pulse == 4'b1111) n_full++;
            else if (rise_pulse != 4'b0000) n_part++;
        end
        checks++;
        if ((lvl_at !== 6) || (n_full !== 1) || (n_part !== 0)) begin
            errors++;
            $display("FAIL simul_rise: got level@%0d full %0d partial %0d expected 6 1 0",
                     lvl_at, n_full, n_part);
        end
        raw_in = 4'b0000;
        lvl_at = 0;
        n_full = 0;
        n_part = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if ((level_out == 4'b0000) && (lvl_at == 0)) lvl_at = i;
            if (fall_pulse == 4'b1111) n_full++;
            else if (fall_pulse != 4'b0000) n_part++;
            if (rise_pulse != 4'b0000) n_part++;
        end
        checks++;
        if ((lvl_at !== 6) || (n_full !== 1) || (n_part !== 0)) begin
            errors++;
            $display("FAIL simul_fall: got level@%0d full %0d other %0d expected 6 1 0",
                     lvl_at, n_full, n_part);
        end
    endtask

    task automatic test_reset_mid();
        int first = 0;
        int n_rise = 0;
        do_reset();
        raw_in = 4'b0100;
        // Two cycles into the count: the synchronizer has settled and the
        // counter has advanced twice.
        repeat (4) @(negedge clk);
        btn_reset = 1'b1;
        #1;
        checks++;
        if ({level_out, rise_pulse, fall_pulse} !== 12'h000) begin
            errors++;
            $display("FAIL midreset_async: got %h expected 000", {level_out, rise_pulse, fall_pulse});
        end
        @(negedge clk);
        btn_reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if ({rise_pulse, fall_pulse} !== 8'h00) begin
                    errors++;
                    $display("FAIL midreset_release_pulse: got %h expected 00", {rise_pulse, fall_pulse});
                end
            end
            if (level_out[2] && (first == 0)) first = i;
            if (rise_pulse[2]) n_rise++;
        end
        checks++;
        if ((first !== 6) || (n_rise !== 1)) begin
            errors++;
            $display("FAIL midreset_requal: got level@%0d pulses %0d expected 6 1", first, n_rise);
        end
    endtask

    task automatic test_autorepeat();
        int got_q[$];
        int exp_q[$];
        int n_fall = 0;
        int fall_at = 0;
        int late_rise = 0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        exp_q = '{6, 16, 21, 26, 31, 36};
`else
        exp_q = '{6};
`endif
        do_reset();
        raw_in = 4'b1000;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rise_pulse[3]) got_q.push_back(i);
            checks++;
            if (rise_pulse !== m_rise) begin
                errors++;
                $display("FAIL repeat_model: cycle %0d got %b expected %b", i, rise_pulse, m_rise);
            end
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL repeat_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL repeat_pos%0d: got %0d expected %0d", k, got_q[k], exp_q[k]);
                end
            end
        end
        raw_in = 4'b0000;
        for (int i = 41; i <= 60; i++) begin
            @(negedge clk);
            if (fall_pulse[3]) begin
                n_fall++;
                fall_at = i;
            end
            if (rise_pulse[3] && (n_fall > 0)) late_rise++;
        end
        checks++;
        if ((n_fall !== 1) || (fall_at !== 46) || (late_rise !== 0)) begin
            errors++;
            $display("FAIL repeat_release: got falls %0d at %0d late rises %0d expected 1 46 0",
                     n_fall, fall_at, late_rise);
        end
    endtask

    task automatic test_random();
        int hold [N_CH];
        do_reset();
        for (int ch = 0; ch < N_CH; ch++) hold[ch] = 0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            @(negedge clk);
            checks++;
            if (level_out !== m_level) begin
                errors++;
                $display("FAIL rand_level: cycle %0d got %b expected %b", cyc, level_out, m_level);
            end
            checks++;
            if (rise_pulse !== m_rise) begin
                errors++;
                $display("FAIL rand_rise: cycle %0d got %b expected %b", cyc, rise_pulse, m_rise);
            end
            checks++;
            if (fall_pulse !== m_fall) begin
                errors++;
                $display("FAIL rand_fall: cycle %0d got %b expected %b", cyc, fall_pulse, m_fall);
            end
            checks++;
            if ((rise_pulse & fall_pulse) !== 4'b0000) begin
                errors++;
                $display("FAIL rand_exclusive: cycle %0d got %b expected 0000", cyc,
                         rise_pulse & fall_pulse);
            end
            btn_reset = ((cyc == 500) || (cyc == 501)) ? 1'b1 : 1'b0;
            for (int ch = 0; ch < N_CH; ch++) begin
                if (hold[ch] == 0) begin
                    raw_in[ch] = 1'($urandom_range(0, 1));
                    hold[ch] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 40))
                                                           : int'($urandom_range(1, 7));
                end else begin
                    hold[ch] = hold[ch] - 1;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_autorepeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
